pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RISC-V core. Collects stall requests from IF, ID, EX and MEM and drives a per-stage stall vector to the pipeline registers (pc, if_id, id_ex, ex_mem, mem_wb). Sequences taken-branch/jump redirects from EX: it flushes the IF/ID and ID/EX registers and redirects the PC. A redirect that arrives while EX is frozen is held pending until the freeze releases. Provides saturating stall and flush performance counters.

---
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall-vector generation, branch redirect sequencing and perf counters for the 5-stage core.
// Revision: 1.0
`default_nettype none

module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             new_pc_valid_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pend_pc;
  logic [31:0]      w_pend_pc_nxt;
  logic [5:0]       w_stall_raw;
  logic             w_ex_frozen;
  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_pending;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Freezing a stage also freezes every stage upstream of it.
  always_comb begin
    w_stall_raw = 6'b000000;
    if (stallreq_mem)     w_stall_raw = 6'b011111;
    else if (stallreq_ex) w_stall_raw = 6'b001111;
    else if (stallreq_id) w_stall_raw = 6'b000111;
    else if (stallreq_if) w_stall_raw = 6'b000011;
  end

  assign w_ex_frozen = w_stall_raw[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // While pending, EX keeps re-asserting the same branch, so branch_flag_i is ignored.
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_pc_nxt = r_pend_pc;
    w_redirect    = 1'b0;
    w_target      = '0;
    w_pending     = 1'b0;
    case (r_state)
      IDLE: begin
        if (branch_flag_i) begin
          if (!w_ex_frozen) begin
            w_redirect = 1'b1;
            w_target   = branch_target_i;
          end else begin
            w_state_nxt   = PEND;
            w_pend_pc_nxt = branch_target_i;
          end
        end
      end
      PEND: begin
        w_pending = 1'b1;
        if (!w_ex_frozen) begin
          w_redirect  = 1'b1;
          w_target    = r_pend_pc;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign stall_o        = rst ? 6'b000000 : w_stall_raw;
  assign flush_o        = !rst && w_redirect;
  assign new_pc_valid_o = !rst && w_redirect;
  assign new_pc_o       = rst ? 32'h0 : w_target;
  assign pending_o      = !rst && w_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_o[0] && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_o && (r_flush_cnt != {CNT_W{1'b1}}))    r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with narrow counters so saturation is reachable.
`default_nettype none

module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sif, sid, sex, smem, br;
  logic [31:0]   tgt;
  logic [5:0]    stall_o;
  logic          flush_o, npv_o, pend_o;
  logic [31:0]   npc_o;
  logic [CW-1:0] scnt_o, fcnt_o;

  typedef struct packed {
    logic [5:0]    stall;
    logic          flush;
    logic          npv;
    logic [31:0]   npc;
    logic          pend;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic          m_pend = 1'b0;
  logic [31:0]   m_pc   = '0;
  logic [CW-1:0] m_scnt = '0;
  logic [CW-1:0] m_fcnt = '0;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .branch_flag_i(br), .branch_target_i(tgt),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(npc_o), .new_pc_valid_o(npv_o),
    .pending_o(pend_o), .stall_cnt_o(scnt_o), .flush_cnt_o(fcnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, compare, then advance the model across the edge.
  task automatic cyc(input logic r, input logic i_f, input logic i_d, input logic e,
                     input logic m, input logic b, input logic [31:0] t);
    exp_t e_v, got;
    logic [5:0] raw;
    logic pend_n;
    logic [31:0] pc_n;
    @(negedge clk);
    rst = r; sif = i_f; sid = i_d; sex = e; smem = m; br = b; tgt = t;
    raw = m ? 6'b011111 : e ? 6'b001111 : i_d ? 6'b000111 : i_f ? 6'b000011 : 6'b000000;
    e_v = '0;
    pend_n = m_pend;
    pc_n = m_pc;
    e_v.scnt = m_scnt;
    e_v.fcnt = m_fcnt;
    if (!r) begin
      e_v.stall = raw;
      if (!m_pend) begin
        if (b && !raw[3]) begin
          e_v.flush = 1'b1; e_v.npv = 1'b1; e_v.npc = t;
        end else if (b) begin
          pend_n = 1'b1; pc_n = t;
        end
      end else begin
        e_v.pend = 1'b1;
        if (!raw[3]) begin
          e_v.flush = 1'b1; e_v.npv = 1'b1; e_v.npc = m_pc; pend_n = 1'b0;
        end
      end
    end
    q.push_back(e_v);
    #1;
    got = q.pop_front();
    check("stall_o",        {58'd0, stall_o}, {58'd0, got.stall});
    check("flush_o",        {63'd0, flush_o}, {63'd0, got.flush});
    check("new_pc_valid_o", {63'd0, npv_o},   {63'd0, got.npv});
    check("new_pc_o",       {32'd0, npc_o},   {32'd0, got.npc});
    check("pending_o",      {63'd0, pend_o},  {63'd0, got.pend});
    check("stall_cnt_o",    {60'd0, scnt_o},  {60'd0, got.scnt});
    check("flush_cnt_o",    {60'd0, fcnt_o},  {60'd0, got.fcnt});
    if (r) begin
      m_pend = 1'b0; m_pc = '0; m_scnt = '0; m_fcnt = '0;
    end else begin
      m_pend = pend_n; m_pc = pc_n;
      if (got.stall[0] && m_scnt != {CW{1'b1}}) m_scnt = m_scnt + 1'b1;
      if (got.flush && m_fcnt != {CW{1'b1}})    m_fcnt = m_fcnt + 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; sif = 0; sid = 0; sex = 0; smem = 0; br = 0; tgt = '0;
    // Reset, including forcing of outputs against active requests
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 1, 1, 32'hDEAD_BEEF);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 32'h0);
    // Priority
    cyc(0, 1, 0, 0, 1, 0, 32'h0);
    cyc(0, 0, 1, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    // Immediate redirect
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_0100);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    // Pending redirect under MEM stall
    repeat (3) cyc(0, 0, 0, 0, 1, 1, 32'h0000_0200);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    // Redirect under IF stall, then ID stall
    cyc(0, 1, 0, 0, 0, 1, 32'h0000_0300);
    cyc(0, 0, 1, 0, 0, 1, 32'h0000_0380);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    // Reset mid-PEND discards the captured redirect
    cyc(0, 0, 0, 1, 0, 1, 32'h0000_0400);
    cyc(0, 0, 0, 1, 0, 1, 32'h0000_0400);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 32'h0);
    // Branch inputs ignored while pending and on the release cycle
    cyc(0, 0, 0, 1, 0, 1, 32'h0000_0500);
    cyc(0, 0, 0, 1, 0, 1, 32'h0000_0600);
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_0700);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    // Counter saturation
    repeat (20) cyc(0, 0, 1, 0, 0, 0, 32'h0);
    repeat (20) cyc(0, 0, 0, 0, 0, 1, 32'h1000);
    // Random traffic
    for (int k = 0; k < 60; k++) begin
      cyc(($urandom_range(0, 19) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
